// File: rtl/cv32e40p_tmr_fault_manager_if.sv
// cv32e40p_tmr_fault_manager_if: fault inputs, replay handshake and status of the TMR fault manager.
interface cv32e40p_tmr_fault_manager_if #(
    parameter int N_SRC = 4,
    parameter int CNT_W = 8
);
    logic [N_SRC-1:0] fault_i;
    logic             enable_i;
    logic             clear_i;
    logic             replay_ack_i;
    logic             replay_req_o;
    logic             permanent_o;
    logic [N_SRC-1:0] fault_src_o;
    logic [CNT_W-1:0] fault_cnt_o;
    logic [1:0]       state_o;
    modport master (
        output fault_i, enable_i, clear_i, replay_ack_i,
        input  replay_req_o, permanent_o, fault_src_o, fault_cnt_o, state_o
    );
    modport slave (
        input  fault_i, enable_i, clear_i, replay_ack_i,
        output replay_req_o, permanent_o, fault_src_o, fault_cnt_o, state_o
    );
endinterface

// File: rtl/cv32e40p_tmr_fault_manager.sv
// cv32e40p_tmr_fault_manager: replays transient TMR faults and declares a sticky
// permanent fault when THRESH faults land inside one WINDOW-cycle window.
module cv32e40p_tmr_fault_manager #(
    parameter int N_SRC  = 4,
    parameter int CNT_W  = 8,
    parameter int WINDOW = 1024,
    parameter int THRESH = 4
) (
    input logic clk,
    input logic rst,
    cv32e40p_tmr_fault_manager_if.slave bus
);
    localparam int TW = $clog2(WINDOW);
    localparam int WW = $clog2(THRESH + 1);
    typedef enum logic [1:0] {OK = 2'b00, REPLAY = 2'b01, PERM = 2'b10} state_t;
    state_t           state_q, state_d;
    logic             replay_q, replay_d;
    logic             perm_q, perm_d;
    logic [N_SRC-1:0] src_q, src_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [TW-1:0]    timer_q, timer_d;
    logic [WW-1:0]    win_q, win_d;
    logic             f, wrap, hit;
    always_comb begin
        f       = |(bus.fault_i & {N_SRC{bus.enable_i}});
        wrap    = timer_q == TW'(WINDOW - 1);
        timer_d = wrap ? '0 : timer_q + 1'b1;
        // the wrap cycle opens a fresh window, so only this cycle's fault counts
        hit     = f && ((wrap ? 9'd0 : 9'(win_q)) + 9'd1 >= 9'(THRESH));
        win_d   = wrap ? WW'(f) : (f && win_q != WW'(THRESH)) ? win_q + 1'b1 : win_q;
        cnt_d   = (f && !(&cnt_q)) ? cnt_q + 1'b1 : cnt_q;
        src_d   = src_q | (bus.fault_i & {N_SRC{bus.enable_i}});
        state_d = (hit || state_q == PERM) ? PERM :
                  (f || (state_q == REPLAY && !bus.replay_ack_i)) ? REPLAY : OK;
        if (bus.clear_i) begin
            state_d = OK;
            cnt_d   = '0;
            src_d   = '0;
            win_d   = '0;
        end
        replay_d = state_d == REPLAY;
        perm_d   = state_d == PERM;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= OK;
            replay_q <= 1'b0;
            perm_q   <= 1'b0;
            src_q    <= '0;
            cnt_q    <= '0;
            timer_q  <= '0;
            win_q    <= '0;
        end else begin
            state_q  <= state_d;
            replay_q <= replay_d;
            perm_q   <= perm_d;
            src_q    <= src_d;
            cnt_q    <= cnt_d;
            timer_q  <= timer_d;
            win_q    <= win_d;
        end
    end
    assign bus.state_o      = state_q;
    assign bus.replay_req_o = replay_q;
    assign bus.permanent_o  = perm_q;
    assign bus.fault_src_o  = src_q;
    assign bus.fault_cnt_o  = cnt_q;
endmodule

// File: tb/tb_cv32e40p_tmr_fault_manager.sv
// tb_cv32e40p_tmr_fault_manager: two configurations driven in lockstep against a
// window-arithmetic reference model, plus directed literal checks.
module tb_cv32e40p_tmr_fault_manager;
    logic       clk = 1'b0;
    logic       rst = 1'b1, clr = 1'b0, ack = 1'b0, en = 1'b1;
    logic [3:0] fault = 4'b0;
    bit         chk = 1'b0;
    int         n_cmp = 0, n_fail = 0;

    always #5 clk = ~clk;

    cv32e40p_tmr_fault_manager_if #(.N_SRC(4), .CNT_W(8)) if0 ();
    cv32e40p_tmr_fault_manager_if #(.N_SRC(4), .CNT_W(2)) if1 ();
    assign if0.fault_i = fault;
    assign if0.enable_i = en;
    assign if0.clear_i = clr;
    assign if0.replay_ack_i = ack;
    assign if1.fault_i = fault;
    assign if1.enable_i = en;
    assign if1.clear_i = clr;
    assign if1.replay_ack_i = ack;

    cv32e40p_tmr_fault_manager #(.N_SRC(4), .CNT_W(8), .WINDOW(1024), .THRESH(4))
        u0 (.clk(clk), .rst(rst), .bus(if0.slave));
    cv32e40p_tmr_fault_manager #(.N_SRC(4), .CNT_W(2), .WINDOW(16), .THRESH(2))
        u1 (.clk(clk), .rst(rst), .bus(if1.slave));

    // Reference model: a window covers absolute cycles [k*W-1, (k+1)*W-2] after reset,
    // so its id is (t+1)/W; nwin counts faults seen in the current window since clear.
    int         mw[2]   = '{1024, 16};
    int         mth[2]  = '{4, 2};
    int         mmax[2] = '{255, 3};
    int         t[2], wid[2], nwin[2], cnt[2], st[2];
    logic [3:0] src[2];

    task automatic model_step();
        bit f, hit;
        int w;
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                t[k] = 0; wid[k] = 0; nwin[k] = 0; cnt[k] = 0; st[k] = 0; src[k] = 4'b0;
            end else begin
                f = en && (fault != 4'b0);
                w = (t[k] + 1) / mw[k];
                if (w != wid[k]) begin
                    wid[k] = w;
                    nwin[k] = 0;
                end
                if (clr) begin
                    st[k] = 0; cnt[k] = 0; src[k] = 4'b0; nwin[k] = 0;
                end else begin
                    hit = f && (nwin[k] + 1 >= mth[k]);
                    if (f) begin
                        nwin[k]++;
                        if (cnt[k] < mmax[k]) cnt[k]++;
                        src[k] = src[k] | fault;
                    end
                    case (st[k])
                        0: st[k] = hit ? 2 : (f ? 1 : 0);
                        1: st[k] = hit ? 2 : ((ack && !f) ? 0 : 1);
                        default: st[k] = 2;
                    endcase
                end
                t[k]++;
            end
        end
    endtask

    task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            cmp("u0.state", 32'(if0.state_o), 32'(st[0]));
            cmp("u0.replay", 32'(if0.replay_req_o), 32'(st[0] == 1));
            cmp("u0.perm", 32'(if0.permanent_o), 32'(st[0] == 2));
            cmp("u0.cnt", 32'(if0.fault_cnt_o), 32'(cnt[0]));
            cmp("u0.src", 32'(if0.fault_src_o), 32'(src[0]));
            cmp("u1.state", 32'(if1.state_o), 32'(st[1]));
            cmp("u1.replay", 32'(if1.replay_req_o), 32'(st[1] == 1));
            cmp("u1.perm", 32'(if1.permanent_o), 32'(st[1] == 2));
            cmp("u1.cnt", 32'(if1.fault_cnt_o), 32'(cnt[1]));
            cmp("u1.src", 32'(if1.fault_src_o), 32'(src[1]));
        end
    end

    task automatic tick(input logic r, input logic c, input logic a, input logic e,
                        input logic [3:0] fv);
        rst = r; clr = c; ack = a; en = e; fault = fv;
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick(0, 0, 0, 1, 4'b0);
    endtask

    task automatic to_timer1(input int v);
        for (int i = 0; i < 16 && (t[1] % 16) != v; i++) idle(1);
    endtask

    initial begin
        @(negedge clk);
        tick(1, 0, 0, 1, 4'b0);
        tick(1, 0, 0, 1, 4'b0);
        chk = 1'b1;
        cmp("rst.state", 32'(if0.state_o), 32'd0);
        cmp("rst.cnt", 32'(if0.fault_cnt_o), 32'd0);
        // single fault and ack
        tick(0, 0, 0, 1, 4'b0010);
        cmp("single.replay", 32'(if0.replay_req_o), 32'd1);
        cmp("single.state", 32'(if0.state_o), 32'd1);
        cmp("single.cnt", 32'(if0.fault_cnt_o), 32'd1);
        cmp("single.src", 32'(if0.fault_src_o), 32'h2);
        idle(2);
        tick(0, 0, 1, 1, 4'b0);
        cmp("ack.state", 32'(if0.state_o), 32'd0);
        cmp("ack.replay", 32'(if0.replay_req_o), 32'd0);
        // threshold in one window
        tick(0, 1, 0, 1, 4'b0);
        for (int i = 0; i < 4; i++) begin
            tick(0, 0, 0, 1, 4'b0100);
            if (i < 3) begin
                tick(0, 0, 1, 1, 4'b0);
                idle(8);
            end
        end
        cmp("thr.state", 32'(if0.state_o), 32'd2);
        cmp("thr.perm", 32'(if0.permanent_o), 32'd1);
        cmp("thr.replay", 32'(if0.replay_req_o), 32'd0);
        cmp("thr.cnt", 32'(if0.fault_cnt_o), 32'd4);
        tick(0, 0, 1, 1, 4'b0001);
        cmp("thr.extra_cnt", 32'(if0.fault_cnt_o), 32'd5);
        cmp("thr.stay", 32'(if0.state_o), 32'd2);
        // ack and fault together in REPLAY
        tick(0, 1, 0, 1, 4'b0);
        tick(0, 0, 0, 1, 4'b0001);
        tick(0, 0, 1, 1, 4'b1000);
        cmp("sim.state", 32'(if0.state_o), 32'd1);
        cmp("sim.replay", 32'(if0.replay_req_o), 32'd1);
        cmp("sim.cnt", 32'(if0.fault_cnt_o), 32'd2);
        tick(0, 0, 1, 1, 4'b0);
        // window expiry on the 16-cycle instance
        tick(0, 1, 0, 1, 4'b0);
        to_timer1(3);
        tick(0, 0, 0, 1, 4'b0001);
        tick(0, 0, 1, 1, 4'b0);
        to_timer1(3);
        tick(0, 0, 0, 1, 4'b0001);
        tick(0, 0, 1, 1, 4'b0);
        cmp("win.perm", 32'(if1.permanent_o), 32'd0);
        cmp("win.cnt", 32'(if1.fault_cnt_o), 32'd2);
        tick(0, 1, 0, 1, 4'b0);
        to_timer1(3);
        tick(0, 0, 0, 1, 4'b0001);
        idle(1);
        tick(0, 0, 0, 1, 4'b0001);
        cmp("win2.state", 32'(if1.state_o), 32'd2);
        cmp("win2.perm", 32'(if1.permanent_o), 32'd1);
        // saturation and clear priority
        tick(0, 1, 0, 1, 4'b0);
        for (int i = 0; i < 6; i++) tick(0, 0, 0, 1, 4'b0001);
        cmp("sat.cnt", 32'(if1.fault_cnt_o), 32'd3);
        tick(0, 1, 0, 1, 4'b0001);
        cmp("clr.cnt", 32'(if1.fault_cnt_o), 32'd0);
        cmp("clr.state", 32'(if1.state_o), 32'd0);
        cmp("clr.src", 32'(if1.fault_src_o), 32'd0);
        // masking, then reset mid-REPLAY
        tick(0, 0, 0, 0, 4'hF);
        cmp("mask.cnt", 32'(if0.fault_cnt_o), 32'd0);
        cmp("mask.state", 32'(if0.state_o), 32'd0);
        tick(0, 0, 0, 1, 4'b0001);
        tick(1, 0, 0, 1, 4'b0);
        cmp("rstr.replay", 32'(if0.replay_req_o), 32'd0);
        cmp("rstr.cnt", 32'(if0.fault_cnt_o), 32'd0);
        // randomized traffic
        for (int i = 0; i < 3000; i++)
            tick(($urandom % 500) == 0, ($urandom % 100) == 0, ($urandom % 3) == 0,
                 ($urandom % 10) != 0, ($urandom % 6) == 0 ? 4'($urandom % 16) : 4'b0);
        chk = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
